seq_mult_3bit: RTL and testbench

- Sequential shift-and-add unsigned multiplier; the stage directly downstream of the half/full adder cells in the 3-bit multiplier project.
- Accepts two WIDTH-bit operands over a valid/ready handshake and iterates one partial-product add per clock.
- Presents a 2*WIDTH-bit product over a second valid/ready handshake.
- Serves as the sequential counterpart and golden cross-check for the combinational array multiplier.

---
 rtl/seq_mult_3bit_pkg.sv | 17 +
 rtl/seq_mult_3bit_shift_add_step.sv | 19 +
 rtl/seq_mult_3bit.sv | 98 +++++++++
 tb/tb_seq_mult_3bit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_3bit_pkg.sv
// rtl/seq_mult_3bit_pkg.sv - shared state encoding, default width and counter sizing for seq_mult_3bit
package seq_mult_3bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 3;

  // Step counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_3bit_shift_add_step.sv
// rtl/seq_mult_3bit_shift_add_step.sv - one combinational shift-and-add iteration
module shift_add_step #(
  parameter int WIDTH = 3
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/seq_mult_3bit.sv
// rtl/seq_mult_3bit.sv - sequential shift-and-add multiplier; SEQ_MULT_EARLY_EXIT_EN enables early exit
module seq_mult_3bit
  import seq_mult_3bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   product_q;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc_next;
  logic [PW-1:0]   mcand_next;
  logic [WIDTH-1:0] mplier_next;
  logic            last_step;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next)
  );

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // Once no multiplier bits remain, further iterations cannot change acc.
  assign last_step = (cnt == CW'(WIDTH - 1)) || (mplier_next == '0);
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)            state_next = ST_CALC;
      ST_CALC: if (last_step)           state_next = ST_DONE;
      ST_DONE: if (out_ready)           state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      mcand  <= PW'(a);
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ST_CALC) begin
      acc    <= acc_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      cnt    <= cnt + CW'(1);
      // Product register only changes on DONE entry, so it holds through IDLE.
      if (last_step) begin
        product_q <= acc_next;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_3bit.sv
// tb/tb_seq_mult_3bit.sv - self-checking bench for seq_mult_3bit
module tb_seq_mult_3bit;

  localparam int W = 3;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam int LAT_B0 = 1;
  localparam int LAT_B3 = 2;
`else
  localparam int LAT_B0 = 3;
  localparam int LAT_B3 = 3;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;
  int in_hs    = 0;
  int out_hs   = 0;

  int             m_phase;
  int             m_left;
  logic [2*W-1:0] m_result;
  logic [2*W-1:0] m_prod;

  seq_mult_3bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_latency(input int bv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Reference: phase 0 idle, 1 computing for m_left edges, 2 result presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_left   <= 0;
      m_result <= '0;
      m_prod   <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_result <= (2*W)'(int'(a) * int'(b));
          m_left   <= exp_latency(int'(b));
          m_phase  <= 1;
        end
        1: if (m_left == 1) begin
          m_phase <= 2;
          m_prod  <= m_result;
        end else begin
          m_left <= m_left - 1;
        end
        2: if (out_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checker_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready_vs_model", int'(in_ready), int'(m_phase == 0));
        check("out_valid_vs_model", int'(out_valid), int'(m_phase == 2));
        check("product_vs_model", int'(product), int'(m_prod));
        if (in_valid && in_ready) in_hs++;
        if (out_valid && out_ready) out_hs++;
      end
    end
  endtask

  task automatic run_op(input int av, input int bv, input int exp_p,
                        input int exp_lat, input int stall);
    int lat;
    @(negedge clk);
    #1;
    a = W'(av);
    b = W'(bv);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("product_literal", int'(product), exp_p);
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        a = 3'd1;
        b = 3'd1;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_product", int'(product), exp_p);
      check("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_hs", int'(in_ready), 1);
    check("out_valid_after_hs", int'(out_valid), 0);
  endtask

  initial begin
    int guard;
    int in_hs0;
    int out_hs0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_product", int'(product), 0);
    fork
      checker_loop();
    join_none
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    run_op(5, 6, 30, 3, 0);
    run_op(7, 7, 49, 3, 5);
    run_op(0, 7, 0, 3, 0);
    run_op(7, 0, 0, LAT_B0, 0);

    // Abort mid-calculation with an asynchronous reset pulse.
    @(negedge clk);
    #1;
    a = 3'd3;
    b = 3'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_product", int'(product), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_no_result", int'(product), 0);
    run_op(2, 3, 6, LAT_B3, 0);

    // Back-to-back sweep of every operand pair.
    in_hs0 = in_hs;
    out_hs0 = out_hs;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check("sweep_accept_timeout", int'(guard < 20), 1);
      a = W'(i >> 3);
      b = W'(i);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    guard = 0;
    while ((!in_ready || out_valid) && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("sweep_drain_timeout", int'(guard < 50), 1);
    out_ready = 1'b0;
    @(negedge clk);
    check("sweep_in_handshakes", in_hs - in_hs0, 64);
    check("sweep_out_handshakes", out_hs - out_hs0, 64);
    check("sweep_last_product", int'(product), 49);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
